// File: rtl/board_frame_decoder_if.sv
// Byte-stream in / board-write out bus for the frame decoder.
// The master side drives start and received bytes; the slave side is the decoder.
interface board_frame_decoder_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data, busy, done, error
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data, busy, done, error
  );
endinterface

// File: rtl/board_frame_decoder.sv
// Decodes an ANSI-style text frame (ESC[;H header, rows of 'O'/' ' cells ending CR LF)
// into one-bit board cell writes, restarting at the header on any illegal byte.
module board_frame_decoder #(
  parameter int unsigned LOG_WIDTH  = 3,
  parameter int unsigned LOG_HEIGHT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  board_frame_decoder_if.slave  bus
);
  localparam logic [7:0] CH_ESC   = 8'd27;
  localparam logic [7:0] CH_ALIVE = 8'd79;
  localparam logic [7:0] CH_DEAD  = 8'd32;
  localparam logic [7:0] CH_CR    = 8'd13;
  localparam logic [7:0] CH_LF    = 8'd10;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CELL, S_CR, S_LF} state_t;

  state_t                state;
  logic [1:0]            hdr_idx;
  logic [LOG_HEIGHT-1:0] row;
  logic [LOG_WIDTH-1:0]  col;
  logic                  xfer_c;
  logic                  illegal_c;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    hdr_byte = 8'd27;
      2'd1:    hdr_byte = 8'd91;
      2'd2:    hdr_byte = 8'd59;
      default: hdr_byte = 8'd72;
    endcase
  endfunction

  assign xfer_c = bus.rx_valid && bus.rx_ready;

  // Byte is out of place for the current frame position
  always_comb begin
    illegal_c = 1'b0;
    if (xfer_c) begin
      case (state)
        S_HDR:   illegal_c = (bus.rx_data != hdr_byte(hdr_idx));
        S_CELL:  illegal_c = (bus.rx_data != CH_ALIVE) && (bus.rx_data != CH_DEAD);
        S_CR:    illegal_c = (bus.rx_data != CH_CR);
        S_LF:    illegal_c = (bus.rx_data != CH_LF);
        default: illegal_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      hdr_idx      <= 2'd0;
      row          <= '0;
      col          <= '0;
      bus.rx_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
      if (illegal_c) begin
        // A stray ESC is treated as the first byte of a fresh header
        bus.error <= 1'b1;
        state     <= S_HDR;
        hdr_idx   <= (bus.rx_data == CH_ESC) ? 2'd1 : 2'd0;
        row       <= '0;
        col       <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state        <= S_HDR;
              hdr_idx      <= 2'd0;
              row          <= '0;
              col          <= '0;
              bus.rx_ready <= 1'b1;
              bus.busy     <= 1'b1;
            end
          end
          S_HDR: begin
            if (xfer_c) begin
              if (hdr_idx == 2'd3) begin
                state   <= S_CELL;
                hdr_idx <= 2'd0;
              end else begin
                hdr_idx <= hdr_idx + 2'd1;
              end
            end
          end
          S_CELL: begin
            if (xfer_c) begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= {row, col};
              bus.wr_data <= (bus.rx_data == CH_ALIVE);
              col         <= col + LOG_WIDTH'(1);
              if (col == '1) state <= S_CR;
            end
          end
          S_CR: begin
            if (xfer_c) state <= S_LF;
          end
          S_LF: begin
            if (xfer_c) begin
              row <= row + LOG_HEIGHT'(1);
              if (row == '1) begin
                state        <= S_IDLE;
                bus.done     <= 1'b1;
                bus.rx_ready <= 1'b0;
                bus.busy     <= 1'b0;
              end else begin
                state <= S_CELL;
              end
            end
          end
          default: begin
            state        <= S_IDLE;
            bus.rx_ready <= 1'b0;
            bus.busy     <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_board_frame_decoder.sv
// Randomized scoreboard bench for board_frame_decoder: a position-based frame model
// predicts writes/done/error with their cycle, and a monitor checks DUT outputs.
module tb_board_frame_decoder;
  localparam int unsigned LW = 3;
  localparam int unsigned LH = 3;
  localparam int W = 1 << LW;
  localparam int H = 1 << LH;
  localparam int FRAME_LEN = 4 + H * (W + 2);

  typedef enum int {EV_WR, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int unsigned due;
    int unsigned addr;
    bit          data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned cyc = 0;
  int asserts = 0;
  int errors = 0;
  int hs_count;
  int wr_seen = 0;
  ev_t sb[$];
  int  m_pos;
  bit  m_done;

  board_frame_decoder_if #(.ADDR_W(LW + LH)) bus ();

  board_frame_decoder #(.LOG_WIDTH(LW), .LOG_HEIGHT(LH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hdr_at(input int i);
    case (i)
      0:       return 8'd27;
      1:       return 8'd91;
      2:       return 8'd59;
      default: return 8'd72;
    endcase
  endfunction

  // Correct byte for frame position p; cell value chosen by caller
  function automatic logic [7:0] gen_byte(input int p, input bit alive);
    int k;
    if (p < 4) return hdr_at(p);
    k = (p - 4) % (W + 2);
    if (k < W) return alive ? 8'd79 : 8'd32;
    if (k == W) return 8'd13;
    return 8'd10;
  endfunction

  function automatic bit cell_val(input int pattern, input int p);
    int r, c;
    r = (p - 4) / (W + 2);
    c = (p - 4) % (W + 2);
    if (pattern == 0) return ((r + c) % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference model: consumes one accepted byte and queues the expected outputs
  task automatic model_byte(input logic [7:0] b);
    int r, k;
    bit legal, is_cell;
    ev_t e;
    is_cell = 1'b0;
    r = 0;
    k = 0;
    if (m_pos < 4) begin
      legal = (b == hdr_at(m_pos));
    end else begin
      r = (m_pos - 4) / (W + 2);
      k = (m_pos - 4) % (W + 2);
      if (k < W) begin
        legal = (b == 8'd79) || (b == 8'd32);
        is_cell = 1'b1;
      end else if (k == W) begin
        legal = (b == 8'd13);
      end else begin
        legal = (b == 8'd10);
      end
    end
    e.due  = cyc + 1;
    e.addr = 0;
    e.data = 1'b0;
    if (!legal) begin
      e.kind = EV_ERR;
      sb.push_back(e);
      m_pos = (b == 8'd27) ? 1 : 0;
    end else begin
      if (is_cell) begin
        e.kind = EV_WR;
        e.addr = r * W + k;
        e.data = (b == 8'd79);
        sb.push_back(e);
      end
      m_pos++;
      if (m_pos == FRAME_LEN) begin
        e.kind = EV_DONE;
        e.addr = 0;
        e.data = 1'b0;
        sb.push_back(e);
        m_done = 1'b1;
      end
    end
  endtask

  task automatic check_event(input ev_kind_t kind);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_output", 32'(kind), 32'hFFFF_FFFF);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", 32'(kind), 32'(e.kind));
    chk("event_cycle", cyc, e.due);
    if (kind == EV_WR) begin
      chk("wr_addr", 32'(bus.wr_addr), e.addr);
      chk("wr_data", 32'(bus.wr_data), 32'(e.data));
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output event
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done && bus.error) chk("done_and_error", 1, 0);
      if (bus.wr_en) begin
        wr_seen++;
        check_event(EV_WR);
      end
      if (bus.done) check_event(EV_DONE);
      if (bus.error) check_event(EV_ERR);
    end
  end

  // Called just after a negedge; returns just after the negedge following the handshake
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited = 0;
    if (gaps) begin
      while ($urandom_range(0, 9) < 3) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.rx_ready) begin
      chk("handshake_timeout", 0, 1);
      bus.rx_valid = 1'b0;
      return;
    end
    model_byte(b);
    hs_count++;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_range(input int pattern, input bit gaps, input int from, input int upto);
    for (int p = from; p < upto; p++) send_byte(gen_byte(p, cell_val(pattern, p)), gaps);
  endtask

  task automatic do_start();
    m_pos = 0;
    m_done = 1'b0;
    hs_count = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("rx_ready_after_start", 32'(bus.rx_ready), 1);
  endtask

  task automatic drain_and_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_rx_ready", 32'(bus.rx_ready), 0);
  endtask

  task automatic offer_in_idle(input int n);
    bus.rx_data  = 8'd27;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_no_accept", 32'(bus.rx_ready), 0);
      chk("idle_not_busy", 32'(bus.busy), 0);
    end
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    int w0;
    int n;
    bus.start    = 1'b0;
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    rst_n        = 1'b0;
    #12;
    chk("reset_outputs", 32'({bus.rx_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
                              bus.busy, bus.done, bus.error}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    offer_in_idle(4);

    // Checkerboard, back-to-back bytes
    w0 = wr_seen;
    do_start();
    send_range(0, 1'b0, 0, FRAME_LEN);
    drain_and_idle();
    chk("checker_handshakes", hs_count, FRAME_LEN);
    chk("checker_writes", wr_seen - w0, W * H);

    // Illegal 'X' at row 2 col 5, then a full legal frame
    w0 = wr_seen;
    do_start();
    send_range(0, 1'b0, 0, 4 + 2 * (W + 2) + 5);
    send_byte(8'd88, 1'b0);
    repeat (2) @(negedge clk);
    chk("writes_before_error", wr_seen - w0, 2 * W + 5);
    send_range(0, 1'b0, 0, FRAME_LEN);
    drain_and_idle();
    chk("writes_after_restart", wr_seen - w0, 2 * W + 5 + W * H);

    // Doubled ESC in header
    do_start();
    send_byte(8'd27, 1'b0);
    send_range(1, 1'b0, 0, FRAME_LEN);
    drain_and_idle();

    // Random gaps, with a start pulse mid-frame that must be ignored
    w0 = wr_seen;
    do_start();
    send_range(0, 1'b1, 0, 40);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_during_start", 32'(bus.busy), 1);
    send_range(0, 1'b1, 40, FRAME_LEN);
    drain_and_idle();
    chk("gap_writes", wr_seen - w0, W * H);
    offer_in_idle(3);

    // Random frames with occasional junk bytes
    for (int f = 0; f < 3; f++) begin
      do_start();
      n = 0;
      while (!m_done && n < 3000) begin
        if ($urandom_range(0, 99) < 4) send_byte(8'($urandom), 1'b1);
        else send_byte(gen_byte(m_pos, 1'($urandom_range(0, 1))), 1'b1);
        n++;
      end
      chk("junk_frame_completed", 32'(m_done), 1);
      drain_and_idle();
    end

    // Reset after 40 cell bytes
    do_start();
    send_range(1, 1'b0, 0, 4 + 4 * (W + 2) + W);
    bus.rx_data  = 8'd13;
    bus.rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({bus.rx_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
                                    bus.busy, bus.done, bus.error}), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_idle", 32'({bus.rx_ready, bus.busy}), 0);
    end
    bus.rx_valid = 1'b0;
    chk("post_reset_no_pending", sb.size(), 0);
    w0 = wr_seen;
    do_start();
    send_range(1, 1'b1, 0, FRAME_LEN);
    drain_and_idle();
    chk("fresh_frame_writes", wr_seen - w0, W * H);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end
endmodule
